tinyalu_responder: RTL
======================

# tinyalu_responder

Synthesizable responder end of the TinyALU start/done command protocol: the counterpart that `tinyalu_bfm` drives and monitors. Samples A, B and op on a rising `start`, executes add/and/xor in one cycle and multiply through a fixed-depth pipeline, then returns `result` with a one-cycle `done` pulse. Sits inside the testbench top as the DUT behind the `tinyalu_bfm` interface, and is reusable as a golden ALU model.

## Interface
- `MUL_LATENCY`, 3, cycles from start-sample edge to the edge that raises `done` for mul; legal range 2..8.
- `clk`  input  1  single clock, all state on posedge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `A`  input  8  operand A, unsigned.
- `B`  input  8  operand B, unsigned.
- `op`  input  3  opcode, encoded per `operation_t`.
- `start`  input  1  command request, held high by the initiator until `done` is seen.
- `done`  output  1  one-cycle completion pulse.
- `result`  output  16  operation result; holds its value between commands.

## Operation
- Opcodes: 000 no_op, 001 add, 010 and, 011 xor, 100 mul, 111 rst_op. Codes 101, 110 and 111 are treated as no_op.
- States:
  - IDLE: on `start` = 1, captures A, B and op.
    - add/and/xor: goes to DONE.
    - mul: goes to MUL.
    - no_op and unused codes: goes to WAIT_LOW.
  - MUL: counts cycles. Goes to DONE when the count reaches `MUL_LATENCY`-1. Goes to IDLE with no `done` if `start` drops.
  - DONE: `done` = 1 for this cycle only, then goes to WAIT_LOW.
  - WAIT_LOW: stays until `start` = 0, then goes to IDLE. This prevents re-execution while the initiator is still dropping `start`.
- Arithmetic, all zero-extended to 16 bits:
  - add: 9-bit sum, carry in bit 8.
  - and / xor: upper byte 0.
  - mul: full 16-bit unsigned product.
- `result` updates only on the edge that raises `done`. no_op and an aborted mul leave `result` unchanged.
- Operand/op changes after the capture edge are ignored until the next IDLE sample.
- `start` = 1 while in DONE or WAIT_LOW is never a new command; a new command requires `start` = 0 seen first.

## Timing
- Reset (`reset_n` = 0, any time, asynchronous): `done` = 0, `result` = 16'h0000, state = IDLE, mul pipeline cleared. Reset mid-mul discards the operation and no `done` follows.
- Latency, with start sampled at edge N:
  - add/and/xor: `done` and `result` valid after edge N+1.
  - mul: `done` and `result` valid after edge N+`MUL_LATENCY`.
- `done` is high for exactly one cycle.
- Earliest next command sample: edge N+L+2, where L is the operation latency (start must be seen low at N+L+1).
- no_op: no `done`. A no_op start held for one edge then dropped returns to IDLE one edge later.

## Structure
- `tinyalu_pkg` holds `operation_t`, the opcode constants, and `TINYALU_MUL_LATENCY_DEFAULT` = 3; the block imports it.
- Sub-module `tinyalu_mul_pipe`: `MUL_LATENCY`-stage registered multiplier with a valid shift chain and a synchronous flush used on abort. The top module holds the FSM, capture registers, single-cycle datapath and output registers.

## Test plan
- add, A = 8'hFF, B = 8'h01, start held until `done` → `result` = 16'h0100; `done` high one cycle after edge N+1.
- and 8'hF0/8'h3C, then xor 8'hF0/8'h3C, back-to-back through the BFM → 16'h0030 then 16'h00CC; exactly two `done` pulses.
- mul 8'hFF × 8'hFF → 16'hFE01; `done` after edge N+3. Repeat with `MUL_LATENCY` = 5 → `done` after edge N+5.
- no_op with `start` high one edge, then add 1+1 → no `done` for no_op; add gives 16'h0002, and `result` holds its prior value in between.
- mul 8'h10 × 8'h10, `start` dropped after one cycle → no `done`, `result` unchanged; next add 8'h01+8'h02 → 16'h0003.
- `reset_n` asserted asynchronously two cycles into mul 8'h12 × 8'h34 → `done` = 0 and `result` = 16'h0000 immediately; no `done` after release; next mul 8'h12 × 8'h34 → 16'h03A8.

Source files
------------

// File: rtl/tinyalu_pkg.sv
// Shared opcode encoding, FSM state type and single-cycle datapath helper
// for the TinyALU responder.
package tinyalu_pkg;

    localparam int unsigned TINYALU_MUL_LATENCY_DEFAULT = 3;
    localparam int unsigned OPND_W = 8;
    localparam int unsigned RES_W  = 16;
    localparam int unsigned OP_W   = 3;

    typedef enum logic [OP_W-1:0] {
        OP_NO  = 3'b000,
        OP_ADD = 3'b001,
        OP_AND = 3'b010,
        OP_XOR = 3'b011,
        OP_MUL = 3'b100,
        OP_RST = 3'b111
    } operation_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DONE,
        S_WAIT_LOW
    } state_t;

    // Add carries into bit 8; logical ops leave the upper byte clear.
    function automatic logic [RES_W-1:0] alu_single(
        input logic [OP_W-1:0]   op,
        input logic [OPND_W-1:0] a,
        input logic [OPND_W-1:0] b
    );
        case (op)
            OP_ADD:  return RES_W'(a) + RES_W'(b);
            OP_AND:  return RES_W'(a & b);
            OP_XOR:  return RES_W'(a ^ b);
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/tinyalu_mul_pipe.sv
// Fixed-depth registered 8x8 multiplier with a valid shift chain; flush
// drops any in-flight operation.
module tinyalu_mul_pipe
    import tinyalu_pkg::*;
#(
    parameter int unsigned STAGES = TINYALU_MUL_LATENCY_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              launch,
    input  logic              flush,
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    output logic              valid,
    output logic [RES_W-1:0]  product
);

    logic [RES_W-1:0]  prod_q [STAGES];
    logic [STAGES-1:0] vld_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                prod_q[i] <= '0;
            end
            vld_q <= '0;
        end else begin
            prod_q[0] <= RES_W'(a) * RES_W'(b);
            for (int i = 1; i < int'(STAGES); i++) begin
                prod_q[i] <= prod_q[i-1];
            end
            if (flush) begin
                vld_q <= '0;
            end else begin
                vld_q <= {vld_q[STAGES-2:0], launch};
            end
        end
    end

    assign valid   = vld_q[STAGES-1];
    assign product = prod_q[STAGES-1];

endmodule

// File: rtl/tinyalu_responder.sv
// TinyALU start/done responder: captures a command on start, runs it through
// the single-cycle datapath or the mul pipeline, and pulses done once.
module tinyalu_responder
    import tinyalu_pkg::*;
#(
    parameter int unsigned MUL_LATENCY = TINYALU_MUL_LATENCY_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [OPND_W-1:0] A,
    input  logic [OPND_W-1:0] B,
    input  logic [OP_W-1:0]   op,
    input  logic              start,
    output logic              done,
    output logic [RES_W-1:0]  result
);

    localparam int unsigned CNT_W = 4;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OPND_W-1:0]  a_q, a_d, b_q, b_d;
    logic [OP_W-1:0]    op_q, op_d;
    logic               done_d;
    logic [RES_W-1:0]   result_d;
    logic               mul_launch_c;
    logic               mul_flush_c;
    logic               mul_valid;
    logic [RES_W-1:0]   mul_prod;

    tinyalu_mul_pipe #(
        .STAGES (MUL_LATENCY)
    ) u_mul_pipe (
        .clk     (clk),
        .reset_n (reset_n),
        .launch  (mul_launch_c),
        .flush   (mul_flush_c),
        .a       (A),
        .b       (B),
        .valid   (mul_valid),
        .product (mul_prod)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            done    <= 1'b0;
            result  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            done    <= done_d;
            result  <= result_d;
        end
    end

    // The capture edge counts as cycle 1 of the multiply.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        done_d       = 1'b0;
        result_d     = result;
        mul_launch_c = 1'b0;
        mul_flush_c  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d  = A;
                    b_d  = B;
                    op_d = op;
                    case (op)
                        OP_ADD, OP_AND, OP_XOR: state_d = S_DONE;
                        OP_MUL: begin
                            state_d      = S_MUL;
                            cnt_d        = CNT_W'(1);
                            mul_launch_c = 1'b1;
                        end
                        default: state_d = S_WAIT_LOW;
                    endcase
                end
            end
            S_MUL: begin
                if (!start) begin
                    state_d     = S_IDLE;
                    mul_flush_c = 1'b1;
                end else if (cnt_q >= CNT_W'(MUL_LATENCY - 1)) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_WAIT_LOW;
                if (op_q == OP_MUL) begin
                    if (mul_valid) begin
                        result_d = mul_prod;
                    end
                end else begin
                    result_d = alu_single(op_q, a_q, b_q);
                end
            end
            S_WAIT_LOW: begin
                if (!start) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
